// File: rtl/mux_pkg.sv
// Shared definitions for the scanning N:1 multiplexer: mode encodings and a
// ceiling-log2 helper usable in constant expressions.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Smallest r such that 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_nto1_dwell_counter.sv
// Dwell counter for the auto-scan mux: counts enabled cycles modulo DWELL and
// flags the last cycle of each dwell period with tick.
module dwell_counter
    import mux_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W = clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_p1;

    // clr wins over en so a load or a drop to manual always restarts the dwell
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1 <= '0;
        end else if (clr) begin
            cnt_p1 <= '0;
        end else if (en) begin
            if (cnt_p1 == LAST) begin
                cnt_p1 <= '0;
            end else begin
                cnt_p1 <= cnt_p1 + 1'b1;
            end
        end
    end

    assign tick = (cnt_p1 == LAST);

endmodule

// File: rtl/mux_scan_nto1.sv
// N-channel, W-bit registered multiplexer with manual select loading and an
// auto-scan mode that dwells DWELL enabled cycles on each channel in turn.
module mux_scan_nto1
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int W     = 1,
    parameter  int DWELL = 4,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] a,
    input  logic              mode,
    input  logic              en,
    input  logic [SEL_W-1:0]  s_in,
    input  logic              s_load,
    output logic [W-1:0]      y,
    output logic [SEL_W-1:0]  s_cur,
    output logic              y_valid,
    output logic              wrap,
    output logic              sel_err
);

    localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W + 1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);

    logic [W-1:0] sel_data_p0;
    logic         load_ok_p0;
    logic         at_last_p0;
    logic         tick_p0;
    logic         cnt_en_p0;
    logic         cnt_clr_p0;
    logic         advance_p0;

    always_comb begin
        sel_data_p0 = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (s_cur == SEL_W'(k)) begin
                sel_data_p0 = a[k*W +: W];
            end
        end
    end

    assign load_ok_p0 = s_load && ({1'b0, s_in} < N_CH_EXT);
    assign at_last_p0 = (s_cur == LAST_CH);

    // A rejected load neither clears nor advances the counter: it simply holds.
    assign cnt_clr_p0 = en && ((mode == MODE_MANUAL) || load_ok_p0);
    assign cnt_en_p0  = en && (mode == MODE_AUTO) && !s_load;
    assign advance_p0 = cnt_en_p0 && tick_p0;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en_p0),
        .clr   (cnt_clr_p0),
        .tick  (tick_p0)
    );

    // ---- stage p0 -> p1: sample data of the current channel, update select ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            s_cur   <= '0;
            y_valid <= 1'b0;
            wrap    <= 1'b0;
            sel_err <= 1'b0;
        end else if (en) begin
            y       <= sel_data_p0;
            y_valid <= 1'b1;
            wrap    <= 1'b0;
            sel_err <= 1'b0;
            if (s_load) begin
                if (load_ok_p0) begin
                    s_cur <= s_in;
                end else begin
                    sel_err <= 1'b1;
                end
            end else if (advance_p0) begin
                if (at_last_p0) begin
                    s_cur <= '0;
                    wrap  <= 1'b1;
                end else begin
                    s_cur <= s_cur + 1'b1;
                end
            end
        end else begin
            wrap    <= 1'b0;
            sel_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Self-checking bench for mux_scan_nto1: directed phases plus randomized traffic
// compared against a behavioural model of the select/dwell/sample rules.
module tb_mux_scan_nto1;

    localparam int N  = 5;
    localparam int WD = 4;
    localparam int DW = 3;
    localparam int SW = 3;

    logic            clk;
    logic            rst_n;
    logic [N*WD-1:0] a;
    logic            mode;
    logic            en;
    logic [SW-1:0]   s_in;
    logic            s_load;
    logic [WD-1:0]   y;
    logic [SW-1:0]   s_cur;
    logic            y_valid;
    logic            wrap;
    logic            sel_err;

    logic            rst_n_w;
    logic [63:0]     a_w;
    logic [7:0]      y_w;
    logic [2:0]      s_cur_w;
    logic            y_valid_w;
    logic            wrap_w;
    logic            sel_err_w;
    logic [2:0]      s_in_w;

    int checks;
    int failures;

    int         m_cur;
    int         m_cnt;
    logic [3:0] m_y;
    logic       m_valid;
    logic       m_wrap;
    logic       m_err;

    mux_scan_nto1 #(.N_CH(N), .W(WD), .DWELL(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .mode    (mode),
        .en      (en),
        .s_in    (s_in),
        .s_load  (s_load),
        .y       (y),
        .s_cur   (s_cur),
        .y_valid (y_valid),
        .wrap    (wrap),
        .sel_err (sel_err)
    );

    mux_scan_nto1 #(.N_CH(8), .W(8), .DWELL(1)) dut_wide (
        .clk     (clk),
        .rst_n   (rst_n_w),
        .a       (a_w),
        .mode    (1'b1),
        .en      (1'b1),
        .s_in    (s_in_w),
        .s_load  (1'b0),
        .y       (y_w),
        .s_cur   (s_cur_w),
        .y_valid (y_valid_w),
        .wrap    (wrap_w),
        .sel_err (sel_err_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cur   = 0;
        m_cnt   = 0;
        m_y     = '0;
        m_valid = 1'b0;
        m_wrap  = 1'b0;
        m_err   = 1'b0;
    endtask

    // Applies one clock edge worth of the spec rules using the inputs present at the edge.
    task automatic model_step();
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (en) begin
            m_y     = 4'((a >> (m_cur * WD)));
            m_valid = 1'b1;
            if (s_load) begin
                if (int'(s_in) < N) begin
                    m_cur = int'(s_in);
                    m_cnt = 0;
                end else begin
                    m_err = 1'b1;
                end
            end else if (mode) begin
                m_cnt++;
                if (m_cnt == DW) begin
                    m_cnt = 0;
                    if (m_cur == N - 1) begin
                        m_cur  = 0;
                        m_wrap = 1'b1;
                    end else begin
                        m_cur++;
                    end
                end
            end else begin
                m_cnt = 0;
            end
        end
    endtask

    task automatic check_all(input string phase);
        check({phase, ".y"},       32'(y),       32'(m_y));
        check({phase, ".s_cur"},   32'(s_cur),   32'(m_cur));
        check({phase, ".y_valid"}, 32'(y_valid), 32'(m_valid));
        check({phase, ".wrap"},    32'(wrap),    32'(m_wrap));
        check({phase, ".sel_err"}, 32'(sel_err), 32'(m_err));
    endtask

    task automatic cycle(input string phase);
        @(posedge clk);
        model_step();
        #1;
        check_all(phase);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        rst_n_w  = 1'b0;
        a        = '0;
        a_w      = {8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
        s_in_w   = '0;
        mode     = 1'b1;
        en       = 1'b1;
        s_in     = '0;
        s_load   = 1'b0;
        model_reset();

        // Reset held with data toggling: everything stays at reset values.
        for (int i = 0; i < 4; i++) begin
            a = (i % 2 == 0) ? 20'hAAAAA : 20'h55555;
            @(posedge clk);
            #1;
            check_all("reset_hold");
        end
        rst_n = 1'b1;

        // Auto scan straight out of reset with fixed data.
        a = 20'h9C3A5;
        for (int i = 0; i < 18; i++) cycle("auto_reset");

        // Manual sweep through every legal channel, one load per cycle.
        mode = 1'b0;
        a    = 20'h6E1B7;
        for (int s = 0; s < N; s++) begin
            s_load = 1'b1;
            s_in   = SW'(s);
            cycle("manual_sweep");
        end
        s_load = 1'b0;
        cycle("manual_sweep");

        // Out-of-range loads are rejected and flagged for one cycle.
        for (int s = 5; s < 8; s++) begin
            s_load = 1'b1;
            s_in   = SW'(s);
            cycle("bad_load");
            s_load = 1'b0;
            cycle("bad_load_after");
        end

        // Auto mode, then freeze with en low and resume.
        mode = 1'b1;
        for (int i = 0; i < 4; i++) cycle("auto_pre_freeze");
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = 20'($urandom);
            cycle("freeze");
        end
        en = 1'b1;
        for (int i = 0; i < 8; i++) cycle("resume");

        // Load during auto scan lands on the loaded channel with a fresh dwell.
        s_load = 1'b1;
        s_in   = 3'd4;
        cycle("auto_load");
        s_load = 1'b0;
        for (int i = 0; i < 6; i++) cycle("auto_load_after");

        // Randomized traffic across all controls.
        for (int i = 0; i < 400; i++) begin
            a      = 20'($urandom);
            en     = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 24) == 0) mode = ~mode;
            s_load = ($urandom_range(0, 6) == 0);
            s_in   = SW'($urandom_range(0, 7));
            cycle("random");
        end

        // Asynchronous reset in the middle of a clock period.
        en     = 1'b1;
        mode   = 1'b1;
        s_load = 1'b0;
        for (int i = 0; i < 4; i++) cycle("pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("async_reset_edge");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cycle("post_async");

        // Wide data, single-cycle dwell: y walks 10..17 and wraps every 8 cycles.
        rst_n_w = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            check("wide.y",       32'(y_w),       32'(8'h10 + ((k - 1) % 8)));
            check("wide.s_cur",   32'(s_cur_w),   32'(k % 8));
            check("wide.wrap",    32'(wrap_w),    32'((k % 8) == 0));
            check("wide.y_valid", 32'(y_valid_w), 32'(1));
            check("wide.sel_err", 32'(sel_err_w), 32'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan_nto1.md
Name: mux_scan_nto1

Overview:
- Parametrised N-channel, W-bit registered multiplexer; next generation of the team's 4:1 mux.
- Adds a selectable auto-scan mode: the select steps through channels on its own, dwelling a programmable number of cycles on each.
- Manual mode keeps a software-loaded select.
- Sits between sampled input banks and a single downstream consumer that needs a time-multiplexed stream with channel tag and wrap marker.

Parameters:
- N_CH, 4, number of input channels (2..256).
- W, 1, bits per channel.
- DWELL, 4, cycles spent on each channel in auto mode (1..65535).
- SEL_W, $clog2(N_CH), select width. Derived localparam; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  N_CH*W  packed channel data; channel k occupies a[k*W +: W].
- mode  input  1  0 = manual, 1 = auto-scan.
- en  input  1  global enable; low freezes all state.
- s_in  input  SEL_W  select value to load.
- s_load  input  1  one-cycle strobe; captures s_in.
- y  output  W  registered selected data.
- s_cur  output  SEL_W  channel currently selected, registered.
- y_valid  output  1  y holds a sample taken since reset.
- wrap  output  1  one-cycle pulse when auto scan steps from N_CH-1 to 0.
- sel_err  output  1  one-cycle pulse when s_load carries s_in >= N_CH.

Behaviour:
- Reset (rst_n low, asynchronous): y=0, s_cur=0, y_valid=0, wrap=0, sel_err=0, dwell counter=0. Release is synchronous to the next clk edge.
- Latency: y at edge t+1 equals channel s_cur(t) data a(t). y and s_cur are therefore always mutually consistent: y belongs to the channel s_cur showed one cycle earlier.
- en=0:
  - All registers hold, including the dwell counter.
  - wrap and sel_err are forced 0.
  - s_load is ignored.
- en=1, sampling:
  - y <= a[s_cur*W +: W].
  - y_valid <= 1, and stays 1 until reset.
- s_load priority: s_load beats auto-advance in the same cycle.
  - If s_in < N_CH: s_cur <= s_in and dwell counter <= 0.
  - If s_in >= N_CH (only possible when N_CH is not a power of 2): s_cur holds, dwell counter holds, sel_err pulses 1 cycle.
- Manual mode (mode=0): s_cur changes only via s_load. Dwell counter is held at 0.
- Auto mode (mode=1), no load:
  - Dwell counter increments each enabled cycle.
  - When the counter reaches DWELL-1: counter <= 0 and s_cur <= (s_cur==N_CH-1) ? 0 : s_cur+1.
  - On the 0 step, wrap pulses in the same cycle s_cur becomes 0 (registered).
  - Each channel is selected for exactly DWELL enabled cycles.
  - DWELL=1 advances every enabled cycle.
- Mode change 0->1: scanning starts from the current s_cur with the counter at 0, so the first dwell is a full DWELL.
- Mode change 1->0: s_cur freezes at its current value and the counter clears.
- Reset mid-scan: immediate return to the reset values; the scan restarts at channel 0.
- Width rules:
  - Counter width is $clog2(DWELL+1).
  - s_cur increment does not rely on natural overflow; the wrap compare is explicit against N_CH-1.

Decomposition:
- Shared package (mux_pkg): MODE_MANUAL=1'b0, MODE_AUTO=1'b1, and a clog2 helper function for tools lacking $clog2.
- One natural sub-module, dwell_counter:
  - Parameter DWELL.
  - Inputs: clk, rst_n, en, clr.
  - Output: tick, asserted on the DWELL-1 count.
- The top holds the select register, the output register and the pulse logic.

Test Plan:
- Reset: hold rst_n=0 with a=4'b1010 toggling -> y=0, s_cur=0, y_valid=0, wrap=0 throughout. Assert rst_n mid-clock -> outputs clear without waiting for an edge.
- Manual sweep (N_CH=4, W=1): a=4'b0110, load s_in=0,1,2,3 one per cycle -> y=0,1,1,0 each one cycle after the load, sel_err never 1.
- Auto scan (N_CH=4, DWELL=2), a=4'b1001, mode=1 from reset:
  - s_cur sequence is 0,0,1,1,2,2,3,3,0,...
  - y follows one cycle behind as 1,1,0,0,0,0,1,1.
  - wrap=1 only in the cycle s_cur returns to 0 (every 8 cycles).
- Load during auto (DWELL=3): at dwell count 1 on channel 1, pulse s_load with s_in=3 -> s_cur=3 next cycle, held 3 full cycles, then 0 with wrap=1.
- Out-of-range and enable (N_CH=5, SEL_W=3):
  - s_load with s_in=6 -> sel_err=1 for one cycle, s_cur unchanged.
  - en=0 for 5 cycles in auto mode -> s_cur, y and counter frozen.
  - Re-enabling resumes the dwell count where it stopped.
- Wide data (N_CH=8, W=8, DWELL=1): a[k]=8'h10+k -> y steps 8'h10..8'h17 then 8'h10, with wrap pulsing once per 8 cycles.
